avr_swirq: RTL and testbench

Parametrised multi-channel software-interrupt controller. It generalises the single PENDSV/PENDSVIE pair to CHANNELS independent pend/enable pairs, and adds three things:
- a fixed-priority vector output;
- a hardware acknowledge that clears the serviced pending bit;
- a prescaled one-shot delay timer that pends a chosen channel after a programmed interval.

It sits on the AVR I/O bus beside the other peripherals and drives one IRQ line into the core's interrupt logic.

---
 rtl/avr_swirq.sv | 164 ++++++++++++++++
 tb/tb_avr_swirq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/avr_swirq.sv
// ============================================================================
//  Module      : avr_swirq
//  Description : Multi-channel software-interrupt controller on the AVR I/O
//                bus. Provides pend/enable pairs, a fixed-priority vector,
//                a hardware acknowledge and a prescaled one-shot delay timer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module avr_swirq #(
    parameter int CHANNELS = 4,
    parameter int PRESCALE = 64,
    parameter int PS_W     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] io_a,
    input  logic       io_re,
    input  logic       io_we,
    output logic [7:0] io_do,
    input  logic [7:0] io_di,
    output logic       irq,
    output logic [2:0] irq_vec,
    input  logic       irq_ack
);

    localparam logic [2:0]      c_a_pend  = 3'd0;
    localparam logic [2:0]      c_a_clr   = 3'd1;
    localparam logic [2:0]      c_a_ie    = 3'd2;
    localparam logic [2:0]      c_a_dcnt  = 3'd3;
    localparam logic [2:0]      c_a_dch   = 3'd4;
    localparam logic [3:0]      c_chans   = 4'(CHANNELS);
    localparam logic [PS_W-1:0] c_ps_max  = PS_W'(PRESCALE - 1);

    logic [CHANNELS-1:0] r_pend;
    logic [CHANNELS-1:0] r_ie;
    logic [7:0]          r_dcnt;
    logic [2:0]          r_dch;
    logic [PS_W-1:0]     r_ps;

    logic                w_we_pend;
    logic                w_we_clr;
    logic                w_we_ie;
    logic                w_we_dcnt;
    logic                w_we_dch;
    logic                w_dch_legal;
    logic                w_tick;
    logic                w_expire;
    logic [CHANNELS-1:0] w_active;
    logic [CHANNELS-1:0] w_set;
    logic [CHANNELS-1:0] w_clr;
    logic [CHANNELS-1:0] w_ack_mask;
    logic [CHANNELS-1:0] w_exp_mask;
    logic [2:0]          w_vec;
    logic [7:0]          w_pend8;
    logic [7:0]          w_active8;
    logic [7:0]          w_ie8;
    logic [7:0]          w_rdata;

    assign w_we_pend   = io_we && (io_a == c_a_pend);
    assign w_we_clr    = io_we && (io_a == c_a_clr);
    assign w_we_ie     = io_we && (io_a == c_a_ie);
    assign w_we_dcnt   = io_we && (io_a == c_a_dcnt);
    assign w_we_dch    = io_we && (io_a == c_a_dch);
    assign w_dch_legal = ({1'b0, io_di[2:0]} < c_chans);

    // A DCNT write restarts the timer, so it pre-empts a tick in the same cycle.
    assign w_tick   = (r_dcnt != 8'd0) && (r_ps == c_ps_max) && !w_we_dcnt;
    assign w_expire = w_tick && (r_dcnt == 8'd1);

    assign w_active = r_pend & r_ie;
    assign irq      = |w_active;
    assign irq_vec  = w_vec;

    always_comb begin
        w_vec = 3'd0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_vec = 3'(i);
            end
        end
    end

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
            assign w_ack_mask[g] = irq_ack && irq && (w_vec == 3'(g));
            assign w_exp_mask[g] = w_expire && (r_dch == 3'(g));
        end
    endgenerate

    assign w_set = (w_we_pend ? io_di[CHANNELS-1:0] : '0) | w_exp_mask;
    assign w_clr = (w_we_clr  ? io_di[CHANNELS-1:0] : '0) | w_ack_mask;

    // Set is applied after clear so that a simultaneous set wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_set;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ie  <= '0;
            r_dch <= 3'd0;
        end else begin
            if (w_we_ie) begin
                r_ie <= io_di[CHANNELS-1:0];
            end
            if (w_we_dch && w_dch_legal) begin
                r_dch <= io_di[2:0];
            end
        end
    end

    // Prescaler idles at 0 whenever no delay is pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dcnt <= 8'd0;
            r_ps   <= '0;
        end else begin
            if (w_we_dcnt) begin
                r_dcnt <= io_di;
                r_ps   <= '0;
            end else if (r_dcnt == 8'd0) begin
                r_ps   <= '0;
            end else if (w_tick) begin
                r_dcnt <= r_dcnt - 8'd1;
                r_ps   <= '0;
            end else begin
                r_ps   <= r_ps + PS_W'(1);
            end
        end
    end

    always_comb begin
        w_pend8                  = 8'h00;
        w_active8                = 8'h00;
        w_ie8                    = 8'h00;
        w_pend8[CHANNELS-1:0]    = r_pend;
        w_active8[CHANNELS-1:0]  = w_active;
        w_ie8[CHANNELS-1:0]      = r_ie;
    end

    always_comb begin
        w_rdata = 8'h00;
        if (io_re) begin
            case (io_a)
                c_a_pend: w_rdata = w_pend8;
                c_a_clr:  w_rdata = w_active8;
                c_a_ie:   w_rdata = w_ie8;
                c_a_dcnt: w_rdata = r_dcnt;
                c_a_dch:  w_rdata = {5'b00000, r_dch};
                default:  w_rdata = 8'h00;
            endcase
        end
    end

    assign io_do = w_rdata;

endmodule

`default_nettype wire

// File: tb/tb_avr_swirq.sv
// ============================================================================
//  Module      : tb_avr_swirq
//  Description : Scoreboard bench for avr_swirq (CHANNELS=4, PRESCALE=4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_avr_swirq;

    logic       clk;
    logic       rst;
    logic [2:0] io_a;
    logic       io_re;
    logic       io_we;
    logic [7:0] io_do;
    logic [7:0] io_di;
    logic       irq;
    logic [2:0] irq_vec;
    logic       irq_ack;
    logic       chk_irq;

    typedef struct {
        string      name;
        logic [7:0] val;
    } exp_t;

    exp_t rd_q[$];
    exp_t irq_q[$];
    int   checks;
    int   errors;

    avr_swirq #(
        .CHANNELS (4),
        .PRESCALE (4),
        .PS_W     (16)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .io_a    (io_a),
        .io_re   (io_re),
        .io_we   (io_we),
        .io_do   (io_do),
        .io_di   (io_di),
        .irq     (irq),
        .irq_vec (irq_vec),
        .irq_ack (irq_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (io_re) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read io_do=%02h required=<none>", io_do);
            end else begin
                e = rd_q.pop_front();
                if (io_do !== e.val) begin
                    errors++;
                    $display("FAIL %s io_do=%02h required=%02h", e.name, io_do, e.val);
                end
            end
        end else begin
            checks++;
            if (io_do !== 8'h00) begin
                errors++;
                $display("FAIL idle_io_do io_do=%02h required=00", io_do);
            end
        end
        if (chk_irq) begin
            checks++;
            if (irq_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_irq_check irq=%0b vec=%0d", irq, irq_vec);
            end else begin
                e = irq_q.pop_front();
                if ({4'b0, irq, irq_vec} !== e.val) begin
                    errors++;
                    $display("FAIL %s irq=%0b vec=%0d required irq=%0b vec=%0d",
                             e.name, irq, irq_vec, e.val[3], e.val[2:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        io_a  = a;
        io_di = d;
        io_we = 1'b1;
        step();
        io_we = 1'b0;
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
    endtask

    // One-cycle observation: read address a and check irq/irq_vec.
    task automatic obs(input logic [2:0] a, input logic [7:0] exp_do,
                       input logic exp_irq, input logic [2:0] exp_vec,
                       input string name);
        rd_q.push_back('{name, exp_do});
        irq_q.push_back('{{name, "_irq"}, {4'b0, exp_irq, exp_vec}});
        io_a    = a;
        io_re   = 1'b1;
        chk_irq = 1'b1;
        step();
        io_re   = 1'b0;
        chk_irq = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b0;
        io_a    = 3'd0;
        io_re   = 1'b0;
        io_we   = 1'b0;
        io_di   = 8'h00;
        irq_ack = 1'b0;
        chk_irq = 1'b0;

        // Reset and defaults
        repeat (3) step();
        rst = 1'b1;
        for (int a = 0; a < 8; a++) begin
            obs(3'(a), 8'h00, 1'b0, 3'd0, "reset_read");
        end

        // Priority and acknowledge
        wr(3'd2, 8'h0F);
        wr(3'd0, 8'h0A);
        obs(3'd1, 8'h0A, 1'b1, 3'd1, "prio_clr_read");
        ack();
        obs(3'd0, 8'h08, 1'b1, 3'd3, "ack1_pend");
        ack();
        obs(3'd0, 8'h00, 1'b0, 3'd0, "ack2_pend");

        // Masking and clear
        wr(3'd2, 8'h00);
        wr(3'd0, 8'h04);
        obs(3'd0, 8'h04, 1'b0, 3'd0, "masked_pend");
        wr(3'd2, 8'h04);
        obs(3'd2, 8'h04, 1'b1, 3'd2, "unmask_ie");
        wr(3'd1, 8'h04);
        obs(3'd0, 8'h00, 1'b0, 3'd0, "clr_pend");
        wr(3'd0, 8'hF0);
        obs(3'd0, 8'h00, 1'b0, 3'd0, "high_bits_pend");

        // Delay timer: pend exactly 12 edges after the DCNT write edge
        wr(3'd2, 8'h02);
        wr(3'd4, 8'h01);
        wr(3'd3, 8'h03);
        for (int k = 0; k <= 12; k++) begin
            obs(3'd3, 8'(3 - k / 4), (k >= 12), (k >= 12) ? 3'd1 : 3'd0, "delay_dcnt");
        end
        obs(3'd0, 8'h02, 1'b1, 3'd1, "delay_pend");
        ack();

        // Cancel mid-count
        wr(3'd3, 8'h02);
        repeat (5) step();
        wr(3'd3, 8'h00);
        for (int k = 0; k < 12; k++) begin
            obs(3'd0, 8'h00, 1'b0, 3'd0, "cancel_pend");
        end

        // Collision: expiry set vs CLR write and ack on channel 0
        wr(3'd2, 8'h01);
        wr(3'd4, 8'h00);
        wr(3'd0, 8'h01);
        wr(3'd3, 8'h01);
        repeat (3) step();
        io_a    = 3'd1;
        io_di   = 8'h01;
        io_we   = 1'b1;
        irq_ack = 1'b1;
        step();
        io_we   = 1'b0;
        irq_ack = 1'b0;
        obs(3'd0, 8'h01, 1'b1, 3'd0, "collide_pend");
        obs(3'd3, 8'h00, 1'b1, 3'd0, "collide_dcnt");

        // Read concurrent with write shows the pre-write value
        io_di = 8'h02;
        io_we = 1'b1;
        obs(3'd0, 8'h01, 1'b1, 3'd0, "rw_prewrite");
        io_we = 1'b0;
        obs(3'd0, 8'h03, 1'b1, 3'd0, "rw_postwrite");

        // Illegal DCH write ignored
        wr(3'd4, 8'h02);
        wr(3'd4, 8'h07);
        obs(3'd4, 8'h02, 1'b1, 3'd0, "dch_illegal");

        // Async reset mid-delay
        wr(3'd1, 8'h0F);
        wr(3'd2, 8'h0F);
        wr(3'd0, 8'h01);
        wr(3'd4, 8'h03);
        wr(3'd3, 8'h05);
        repeat (7) step();
        obs(3'd3, 8'h04, 1'b1, 3'd0, "pre_reset_dcnt");
        rd_q.push_back('{"async_reset_dcnt", 8'h00});
        irq_q.push_back('{"async_reset_irq", 8'h00});
        io_a    = 3'd3;
        io_re   = 1'b1;
        chk_irq = 1'b1;
        #2;
        rst = 1'b0;
        step();
        io_re   = 1'b0;
        chk_irq = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        for (int k = 0; k < 25; k++) begin
            obs(3'd0, 8'h00, 1'b0, 3'd0, "post_reset_pend");
        end

        step();
        checks++;
        if (rd_q.size() != 0 || irq_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain rd=%0d irq=%0d required=0", rd_q.size(), irq_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
